scaler_cfg_ctrl: RTL and testbench
==================================

Name: scaler_cfg_ctrl

Overview:
Command-driven configuration controller for the three-channel HDMI-input scaler/pan/colour-invert path. Accepts single-step edit commands from the key/UART front end and updates a shadow copy of the scaler control codes, with saturation at each code's limits. It commits the shadow to the active outputs only at a frame boundary (rising edge of input VS), so the scaler never sees a mid-frame change. If no VS arrives within a timeout, it commits anyway.

Parameters:
WIDTH_MAX, 62, max horizontal scale code (0 and 62 both mean full 640)
HEIGHT_MAX, 71, max vertical scale code (0 and 71 both mean full 720)
PAN_Y_MAX, 36, max vertical pan code
PAN_X_MAX, 64, max horizontal pan code
TO_WIDTH, 24, timeout counter width; timeout = 2^TO_WIDTH-1 cycles

Ports:
clk_i  in  1  pixel clock, same domain as vs_i
rst_i  in  1  synchronous, active-high reset
vs_i  in  1  input vertical sync, frame start = rising edge
cmd_valid_i  in  1  command present
cmd_ready_o  out  1  command accepted when valid&ready
cmd_target_i  in  3  0 width, 1 height, 2 pan_y, 3 pan_x, 4 colour toggle, 5 restore defaults, 6-7 reserved (no-op)
cmd_dir_i  in  1  1 increment, 0 decrement; ignored for targets 4 and 5
scaler_ctrl_width_o  out  6  active width code
scaler_ctrl_height_o  out  7  active height code
panning_y_ctrl_o  out  6  active pan-Y code
panning_x_ctrl_o  out  7  active pan-X code
color_reverse_ctrl_o  out  1  active invert flag
cfg_update_o  out  1  one-cycle pulse on commit
pending_o  out  1  shadow differs from active; commit outstanding
sat_o  out  1  one-cycle pulse when a step was clipped at a limit
timeout_o  out  1  sticky; set on timeout commit; cleared by reset or by a VS-triggered commit

Behaviour:
- Reset: all active and shadow codes = 0, colour = 0, state IDLE, cfg_update_o = 0, pending_o = 0, sat_o = 0, timeout_o = 0, timeout counter = 0, vs_1d = 0.
- vs_rise = vs_i & ~vs_1d; vs_1d is registered every cycle.
- FSM states:
  - IDLE: cmd_ready_o = 1. On accept, go to CALC.
  - CALC: 1 cycle, cmd_ready_o = 0. Apply the latched command to the shadow, then go to WAIT_VS.
  - WAIT_VS: cmd_ready_o = ~vs_rise. On vs_rise, go to COMMIT (takes priority over a command). Else on accept, go to CALC. Else on timeout counter reaching all-ones, go to COMMIT and set timeout_o.
  - COMMIT: 1 cycle, cmd_ready_o = 0. Active <= shadow, cfg_update_o = 1, then go to IDLE.
- Command latching: target and dir are captured on accept; inputs may change afterwards.
- Increment at MAX and decrement at 0 leave the code unchanged and pulse sat_o in the CALC cycle.
- Colour toggle inverts the shadow flag.
- Restore defaults sets all shadow fields to 0.
- Reserved targets change nothing but still pass through WAIT_VS/COMMIT.
- Timeout counter: clears on entering WAIT_VS and on every accept while in WAIT_VS; increments each WAIT_VS cycle.
- pending_o = 1 from the CALC cycle through the COMMIT cycle; 0 in IDLE. If a command yields shadow == active, the commit still occurs.
- Latency: accept at cycle n gives CALC at n+1 and WAIT_VS from n+2. A vs_rise at cycle m ≥ n+2 gives COMMIT at m+1; outputs change and cfg_update_o = 1 at m+2.
- vs_rise while in IDLE or CALC is ignored; the next rising edge is used.
- Reset mid-operation discards the shadow and any outstanding commit; outputs return to 0 on the next edge.
- Outputs are registered and held between commits.

Test Plan:
- Reset, then width+ ×3 with VS low, then a VS rising edge -> width_o goes 0→3 exactly 2 cycles after the edge; cfg_update_o pulses once; pending_o = 0 afterwards.
- Height at 71, height+ then VS -> sat_o pulses in the CALC cycle; height_o stays 71; cfg_update_o still pulses.
- In WAIT_VS, cmd_valid_i held high in the same cycle as a vs_rise -> cmd_ready_o = 0 that cycle; commit excludes the command; the command is accepted in IDLE afterwards and commits at the following VS.
- pan_x+ ×5, then pan_y− at 0, then colour toggle, all before one VS -> single commit: pan_x = 5, pan_y = 0, colour = 1; sat_o pulsed once.
- TO_WIDTH = 4, width− from 2 with no VS -> commit after 15 WAIT_VS cycles; width = 1; timeout_o = 1. Next VS-triggered commit clears timeout_o.
- Reset asserted during WAIT_VS with a pending pan_x = 10 -> all outputs 0; after release and a VS edge, no cfg_update_o pulse.

Source files
------------

// File: rtl/scaler_cfg_ctrl.sv
// Frame-synchronous configuration controller for the scaler/pan/invert path.
// Edit commands step a shadow copy; the shadow is committed at the next VS rise or on timeout.
module scaler_cfg_ctrl #(
  parameter int WIDTH_MAX  = 62,
  parameter int HEIGHT_MAX = 71,
  parameter int PAN_Y_MAX  = 36,
  parameter int PAN_X_MAX  = 64,
  parameter int TO_WIDTH   = 24
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       vs_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [2:0] cmd_target_i,
  input  logic       cmd_dir_i,
  output logic [5:0] scaler_ctrl_width_o,
  output logic [6:0] scaler_ctrl_height_o,
  output logic [5:0] panning_y_ctrl_o,
  output logic [6:0] panning_x_ctrl_o,
  output logic       color_reverse_ctrl_o,
  output logic       cfg_update_o,
  output logic       pending_o,
  output logic       sat_o,
  output logic       timeout_o
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_WAIT_VS, S_COMMIT} state_t;

  localparam logic [5:0] L_W_MAX  = 6'(WIDTH_MAX);
  localparam logic [6:0] L_H_MAX  = 7'(HEIGHT_MAX);
  localparam logic [5:0] L_PY_MAX = 6'(PAN_Y_MAX);
  localparam logic [6:0] L_PX_MAX = 7'(PAN_X_MAX);
  // Leaving on the edge where the counter would become all-ones gives 2^TO_WIDTH-1 waiting cycles.
  localparam logic [TO_WIDTH-1:0] L_TO_LAST = {{(TO_WIDTH-1){1'b1}}, 1'b0};

  state_t r_state;
  state_t w_nextState;

  logic                r_vs1d;
  logic [2:0]          r_target;
  logic                r_dir;
  logic [TO_WIDTH-1:0] r_toCnt;
  logic                r_timeout;
  logic                r_cfgUpdate;

  logic [5:0] r_shW;
  logic [6:0] r_shH;
  logic [5:0] r_shPy;
  logic [6:0] r_shPx;
  logic       r_shCol;

  logic [5:0] r_actW;
  logic [6:0] r_actH;
  logic [5:0] r_actPy;
  logic [6:0] r_actPx;
  logic       r_actCol;

  logic w_vsRise;
  logic w_accept;
  logic w_toHit;
  logic w_atLimit;

  assign w_vsRise = vs_i & ~r_vs1d;
  assign w_accept = cmd_valid_i & cmd_ready_o;
  assign w_toHit  = (r_toCnt == L_TO_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  // A frame edge in WAIT_VS wins over a command offered in the same cycle.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_nextState = S_CALC;
      S_CALC:    w_nextState = S_WAIT_VS;
      S_WAIT_VS: begin
        if (w_vsRise)     w_nextState = S_COMMIT;
        else if (w_accept) w_nextState = S_CALC;
        else if (w_toHit)  w_nextState = S_COMMIT;
      end
      S_COMMIT:  w_nextState = S_IDLE;
      default:   w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    w_atLimit = 1'b0;
    case (r_target)
      3'd0:    w_atLimit = r_dir ? (r_shW  == L_W_MAX)  : (r_shW  == 6'd0);
      3'd1:    w_atLimit = r_dir ? (r_shH  == L_H_MAX)  : (r_shH  == 7'd0);
      3'd2:    w_atLimit = r_dir ? (r_shPy == L_PY_MAX) : (r_shPy == 6'd0);
      3'd3:    w_atLimit = r_dir ? (r_shPx == L_PX_MAX) : (r_shPx == 7'd0);
      default: w_atLimit = 1'b0;
    endcase
  end

  always_comb begin
    cmd_ready_o = 1'b0;
    pending_o   = 1'b0;
    sat_o       = 1'b0;
    case (r_state)
      S_IDLE:    cmd_ready_o = 1'b1;
      S_CALC:    begin pending_o = 1'b1; sat_o = w_atLimit; end
      S_WAIT_VS: begin pending_o = 1'b1; cmd_ready_o = ~w_vsRise; end
      S_COMMIT:  pending_o = 1'b1;
      default:   cmd_ready_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vs1d      <= 1'b0;
      r_target    <= 3'd0;
      r_dir       <= 1'b0;
      r_toCnt     <= '0;
      r_timeout   <= 1'b0;
      r_cfgUpdate <= 1'b0;
    end else begin
      r_vs1d      <= vs_i;
      r_cfgUpdate <= (r_state == S_COMMIT);
      if (w_accept) begin
        r_target <= cmd_target_i;
        r_dir    <= cmd_dir_i;
      end
      if (r_state == S_CALC) begin
        r_toCnt <= '0;
      end else if (r_state == S_WAIT_VS) begin
        if (w_accept) r_toCnt <= '0;
        else          r_toCnt <= r_toCnt + TO_WIDTH'(1);
        if (w_vsRise)                   r_timeout <= 1'b0;
        else if (!w_accept && w_toHit)  r_timeout <= 1'b1;
      end
    end
  end

  // Steps saturate: a clipped step leaves the code unchanged and only raises sat_o.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_shW    <= 6'd0;
      r_shH    <= 7'd0;
      r_shPy   <= 6'd0;
      r_shPx   <= 7'd0;
      r_shCol  <= 1'b0;
      r_actW   <= 6'd0;
      r_actH   <= 7'd0;
      r_actPy  <= 6'd0;
      r_actPx  <= 7'd0;
      r_actCol <= 1'b0;
    end else if (r_state == S_CALC && !w_atLimit) begin
      case (r_target)
        3'd0: r_shW  <= r_dir ? r_shW  + 6'd1 : r_shW  - 6'd1;
        3'd1: r_shH  <= r_dir ? r_shH  + 7'd1 : r_shH  - 7'd1;
        3'd2: r_shPy <= r_dir ? r_shPy + 6'd1 : r_shPy - 6'd1;
        3'd3: r_shPx <= r_dir ? r_shPx + 7'd1 : r_shPx - 7'd1;
        3'd4: r_shCol <= ~r_shCol;
        3'd5: begin
          r_shW   <= 6'd0;
          r_shH   <= 7'd0;
          r_shPy  <= 6'd0;
          r_shPx  <= 7'd0;
          r_shCol <= 1'b0;
        end
        default: r_shCol <= r_shCol;
      endcase
    end else if (r_state == S_COMMIT) begin
      r_actW   <= r_shW;
      r_actH   <= r_shH;
      r_actPy  <= r_shPy;
      r_actPx  <= r_shPx;
      r_actCol <= r_shCol;
    end
  end

  assign scaler_ctrl_width_o  = r_actW;
  assign scaler_ctrl_height_o = r_actH;
  assign panning_y_ctrl_o     = r_actPy;
  assign panning_x_ctrl_o     = r_actPx;
  assign color_reverse_ctrl_o = r_actCol;
  assign cfg_update_o         = r_cfgUpdate;
  assign timeout_o            = r_timeout;

endmodule

// File: tb/tb_scaler_cfg_ctrl.sv
// Bench for scaler_cfg_ctrl: directed scenarios plus random traffic, all checked
// every cycle against a behavioural model of the command/commit rules.
module tb_scaler_cfg_ctrl;

  localparam int TO_W          = 4;
  localparam int TIMEOUT_CYCLES = (1 << TO_W) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vs = 1'b0;
  logic       cmdValid = 1'b0;
  logic [2:0] cmdTarget = 3'd0;
  logic       cmdDir = 1'b0;
  logic       cmdReady;
  logic [5:0] widthO;
  logic [6:0] heightO;
  logic [5:0] panYO;
  logic [6:0] panXO;
  logic       colO, cfgO, pendO, satO, toO;

  int nTotal = 0;
  int nBad = 0;

  scaler_cfg_ctrl #(.TO_WIDTH(TO_W)) dut (
    .clk_i(clk), .rst_i(rst), .vs_i(vs), .cmd_valid_i(cmdValid), .cmd_ready_o(cmdReady),
    .cmd_target_i(cmdTarget), .cmd_dir_i(cmdDir),
    .scaler_ctrl_width_o(widthO), .scaler_ctrl_height_o(heightO),
    .panning_y_ctrl_o(panYO), .panning_x_ctrl_o(panXO), .color_reverse_ctrl_o(colO),
    .cfg_update_o(cfgO), .pending_o(pendO), .sat_o(satO), .timeout_o(toO)
  );

  always #5 clk = ~clk;

  // Model: editing phase, shadow/active code arrays, and how long we have waited for a frame.
  localparam int P_IDLE = 0, P_APPLY = 1, P_WAIT = 2, P_COMMIT = 3;
  int mPhase = P_IDLE;
  int mMax[4] = '{62, 71, 36, 64};
  int mSh[4];
  int mAct[4];
  int mShCol, mActCol, mTgt, mDir, mWaited;
  bit mVsPrev, mCfg, mTimeout, started;

  function automatic bit expReady();
    if (mPhase == P_IDLE) return 1'b1;
    if (mPhase == P_WAIT) return !(vs && !mVsPrev);
    return 1'b0;
  endfunction

  function automatic bit expSat();
    if (mPhase != P_APPLY || mTgt > 3) return 1'b0;
    return mDir ? (mSh[mTgt] == mMax[mTgt]) : (mSh[mTgt] == 0);
  endfunction

  always @(posedge clk) begin
    bit vsRise, accept;
    if (rst) begin
      started = 1'b1;
      mPhase = P_IDLE; mVsPrev = 0; mCfg = 0; mTimeout = 0;
      mShCol = 0; mActCol = 0; mTgt = 0; mDir = 0; mWaited = 0;
      for (int i = 0; i < 4; i++) begin mSh[i] = 0; mAct[i] = 0; end
    end else begin
      vsRise = vs && !mVsPrev;
      accept = cmdValid && expReady();
      mCfg = 0;
      case (mPhase)
        P_IDLE: if (accept) begin mTgt = cmdTarget; mDir = cmdDir; mPhase = P_APPLY; end
        P_APPLY: begin
          if (mTgt < 4) begin
            if (mDir && mSh[mTgt] < mMax[mTgt]) mSh[mTgt]++;
            else if (!mDir && mSh[mTgt] > 0) mSh[mTgt]--;
          end else if (mTgt == 4) mShCol ^= 1;
          else if (mTgt == 5) begin
            for (int i = 0; i < 4; i++) mSh[i] = 0;
            mShCol = 0;
          end
          mPhase = P_WAIT;
          mWaited = 0;
        end
        P_WAIT: begin
          if (vsRise) begin mPhase = P_COMMIT; mTimeout = 0; end
          else if (accept) begin mTgt = cmdTarget; mDir = cmdDir; mPhase = P_APPLY; end
          else begin
            mWaited++;
            if (mWaited == TIMEOUT_CYCLES) begin mPhase = P_COMMIT; mTimeout = 1; end
          end
        end
        default: begin
          for (int i = 0; i < 4; i++) mAct[i] = mSh[i];
          mActCol = mShCol;
          mCfg = 1;
          mPhase = P_IDLE;
        end
      endcase
      mVsPrev = vs;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nTotal++;
    if (actual !== expected) begin
      nBad++;
      $display("[TB] FAIL %s at %0t: got %0d, want %0d", name, $time, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      checkOutput("ready", 32'(cmdReady), 32'(expReady()));
      checkOutput("width", 32'(widthO), mAct[0]);
      checkOutput("height", 32'(heightO), mAct[1]);
      checkOutput("panY", 32'(panYO), mAct[2]);
      checkOutput("panX", 32'(panXO), mAct[3]);
      checkOutput("colour", 32'(colO), mActCol);
      checkOutput("cfgUpdate", 32'(cfgO), 32'(mCfg));
      checkOutput("pending", 32'(pendO), 32'(mPhase != P_IDLE));
      checkOutput("sat", 32'(satO), 32'(expSat()));
      checkOutput("timeout", 32'(toO), 32'(mTimeout));
    end
  end

  task automatic applyStimulus(input logic v, input logic [2:0] t, input logic d, input logic vsLvl);
    @(posedge clk);
    #2;
    cmdValid = v; cmdTarget = t; cmdDir = d; vs = vsLvl;
  endtask

  // Holds the command until accepted; returns in the cycle after the accept edge.
  task automatic sendCmd(input logic [2:0] t, input logic d, input logic vsLvl);
    int waited = 0;
    bit done = 0;
    applyStimulus(1'b1, t, d, vsLvl);
    while (!done) begin
      @(negedge clk);
      if (cmdReady === 1'b1) done = 1;
      else if (++waited > 200) begin
        checkOutput("acceptBound", 32'(waited), 200);
        done = 1;
      end
    end
    applyStimulus(1'b0, t, d, vsLvl);
  endtask

  // Produces a VS rise and returns at the negedge of the cycle the commit becomes visible.
  task automatic vsPulseCommit();
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic doReset();
    @(posedge clk); #2;
    rst = 1'b1; cmdValid = 1'b0; vs = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    doReset();
    @(negedge clk);
    checkOutput("resetWidth", 32'(widthO), 0);
    checkOutput("resetReady", 32'(cmdReady), 1);

    // Three width steps committed by one frame edge.
    repeat (3) sendCmd(3'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("widthBeforeCommit", 32'(widthO), 0);
    @(negedge clk);
    checkOutput("widthAfterEdge", 32'(widthO), 3);
    checkOutput("cfgPulse", 32'(cfgO), 1);
    @(negedge clk);
    checkOutput("cfgSingle", 32'(cfgO), 0);
    checkOutput("pendingClear", 32'(pendO), 0);

    // Height saturates at its maximum.
    doReset();
    repeat (71) sendCmd(3'd1, 1'b1, 1'b0);
    vsPulseCommit();
    checkOutput("heightMax", 32'(heightO), 71);
    sendCmd(3'd1, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("heightSat", 32'(satO), 1);
    vsPulseCommit();
    checkOutput("heightHeld", 32'(heightO), 71);
    checkOutput("heightCfg", 32'(cfgO), 1);

    // Command offered in the same cycle as a frame edge is deferred.
    doReset();
    sendCmd(3'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 3'd1, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("readyOnVsRise", 32'(cmdReady), 0);
    sendCmd(3'd1, 1'b1, 1'b1);
    checkOutput("collideWidth", 32'(widthO), 1);
    checkOutput("collideHeightExcluded", 32'(heightO), 0);
    vsPulseCommit();
    checkOutput("collideHeightLater", 32'(heightO), 1);

    // Several edits folded into one commit.
    doReset();
    repeat (5) sendCmd(3'd3, 1'b1, 1'b0);
    sendCmd(3'd2, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("panYSat", 32'(satO), 1);
    sendCmd(3'd4, 1'b0, 1'b0);
    vsPulseCommit();
    checkOutput("multiPanX", 32'(panXO), 5);
    checkOutput("multiPanY", 32'(panYO), 0);
    checkOutput("multiColour", 32'(colO), 1);

    // Timeout commit when no frame edge arrives.
    doReset();
    repeat (2) sendCmd(3'd0, 1'b1, 1'b0);
    vsPulseCommit();
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
    sendCmd(3'd0, 1'b0, 1'b0);
    repeat (TIMEOUT_CYCLES + 4) @(negedge clk);
    checkOutput("timeoutWidth", 32'(widthO), 1);
    checkOutput("timeoutFlag", 32'(toO), 1);
    sendCmd(3'd6, 1'b1, 1'b0);
    vsPulseCommit();
    checkOutput("timeoutCleared", 32'(toO), 0);
    checkOutput("reservedCommit", 32'(cfgO), 1);

    // Reset discards outstanding shadow edits.
    doReset();
    repeat (3) sendCmd(3'd3, 1'b1, 1'b0);
    vsPulseCommit();
    checkOutput("panXBeforeReset", 32'(panXO), 3);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
    repeat (7) sendCmd(3'd3, 1'b1, 1'b0);
    doReset();
    @(negedge clk);
    checkOutput("panXAfterReset", 32'(panXO), 0);
    checkOutput("pendingAfterReset", 32'(pendO), 0);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("noCommitAfterReset", 32'(cfgO), 0);
    end

    // Random traffic against the model.
    begin
      logic vsLvl = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 9) == 0) vsLvl = ~vsLvl;
        applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 3) != 0), vsLvl);
        rst = ($urandom_range(0, 399) == 0);
      end
      rst = 1'b0;
    end
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", nTotal, nBad);
    $finish;
  end

endmodule
